// File: rtl/dm_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: one instance per requester (core, debug/loader).
// The requester uses the master modport and the arbiter uses the slave modport.
interface dm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              req;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW/8-1:0]   be;
    logic [DW-1:0]     wdata;
    logic              gnt;
    logic              rvalid;
    logic [DW-1:0]     rdata;
    logic              stall;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, stall
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, stall
    );
endinterface

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: core has priority, debug/loader is served within MAX_WAIT cycles.
// Optional macro DM_ARB_PERF_EN adds a saturating core/debug conflict counter output.
module dm_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_arbiter_if.slave      core,
    dm_arbiter_if.slave      dbg,
    output logic             mem_en,
    output logic [DW/8-1:0]  mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]      conflict_cnt
`endif
);
    localparam int            BW         = DW / 8;
    localparam logic [3:0]    MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [AW-1:0] ADDR_MASK  = ~AW'(3);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic          lock_reg, lock_next;
    owner_t        rd_owner_reg, rd_owner_next;
    logic [DW-1:0] core_rdata_reg, core_rdata_next;
    logic [DW-1:0] dbg_rdata_reg, dbg_rdata_next;

    logic          dbg_win;
    logic          core_gnt;
    logic          dbg_gnt;
    logic          core_rvalid;
    logic          dbg_rvalid;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [BW-1:0] sel_be;
    logic [DW-1:0] sel_wdata;

    // Debug wins when the core is idle, when it has waited long enough, or while a write burst holds the lock.
    // No grants at all while reset is asserted.
    always_comb begin
        dbg_win  = dbg.req & (~core.req | (wait_cnt_reg == MAX_WAIT_C) | lock_reg);
        core_gnt = rst_n & core.req & ~dbg_win;
        dbg_gnt  = rst_n & dbg_win;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        if (core_gnt) begin
            sel_we    = core.we;
            sel_addr  = core.addr;
            sel_be    = core.be;
            sel_wdata = core.wdata;
        end else if (dbg_gnt) begin
            sel_we    = dbg.we;
            sel_addr  = dbg.addr;
            sel_be    = dbg.be;
            sel_wdata = dbg.wdata;
        end
    end

    assign mem_en    = core_gnt | dbg_gnt;
    assign mem_addr  = sel_addr & ADDR_MASK;
    assign mem_wdata = sel_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < BW; gi++) begin : g_mem_we
            assign mem_we[gi] = sel_be[gi] & sel_we;
        end
    endgenerate

    // Read data passes straight through in the return cycle; afterwards each port holds its last word.
    assign core_rvalid = rst_n & (rd_owner_reg == OWN_CORE);
    assign dbg_rvalid  = rst_n & (rd_owner_reg == OWN_DBG);

    assign core.gnt    = core_gnt;
    assign core.stall  = core.req & ~core_gnt;
    assign core.rvalid = core_rvalid;
    assign core.rdata  = core_rvalid ? mem_rdata : core_rdata_reg;

    // The debug port never stalls a pipeline; its stall mirrors the losing condition for observability.
    assign dbg.gnt     = dbg_gnt;
    assign dbg.stall   = dbg.req & ~dbg_gnt;
    assign dbg.rvalid  = dbg_rvalid;
    assign dbg.rdata   = dbg_rvalid ? mem_rdata : dbg_rdata_reg;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (dbg_gnt || !dbg.req) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != MAX_WAIT_C) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end

        lock_next = dbg.req & (lock_reg | (dbg_gnt & dbg.we));

        rd_owner_next = OWN_NONE;
        if (core_gnt && !core.we) begin
            rd_owner_next = OWN_CORE;
        end else if (dbg_gnt && !dbg.we) begin
            rd_owner_next = OWN_DBG;
        end

        core_rdata_next = core_rvalid ? mem_rdata : core_rdata_reg;
        dbg_rdata_next  = dbg_rvalid ? mem_rdata : dbg_rdata_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg   <= '0;
            lock_reg       <= 1'b0;
            rd_owner_reg   <= OWN_NONE;
            core_rdata_reg <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            wait_cnt_reg   <= wait_cnt_next;
            lock_reg       <= lock_next;
            rd_owner_reg   <= rd_owner_next;
            core_rdata_reg <= core_rdata_next;
            dbg_rdata_reg  <= dbg_rdata_next;
        end
    end

`ifdef DM_ARB_PERF_EN
    logic [31:0] conflict_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt_reg <= '0;
        end else if (core.req && dbg.req && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: per-cycle vector table plus hand-written reset/lock sequences,
// with a read-return scoreboard backed by a behavioural single-port memory.
module tb_dm_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) core_bus ();
    dm_arbiter_if #(.AW(AW), .DW(DW)) dbg_bus ();

    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DM_ARB_PERF_EN
    logic [31:0]   conflict_cnt;
`endif

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core      (core_bus),
        .dbg       (dbg_bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DM_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Behavioural memory: one-cycle registered read, byte-enabled write, reloaded during reset.
    logic [31:0] mem_arr [0:63];
    logic [5:0]  widx;
    assign widx = 6'(mem_addr >> 2);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            for (int b = 0; b < BW; b++)
                if (mem_we[b]) mem_arr[widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem_arr[widx];
        end
    end

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [3:0]  cbe;
        logic [31:0] cwd;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [3:0]  dbe;
        logic [31:0] dwd;
        logic        exp_cg;
        logic        exp_dg;
    } vec_t;

    typedef struct {
        bit          is_dbg;
        logic [31:0] data;
    } rd_exp_t;

    vec_t        tbl[$];
    rd_exp_t     sb[$];
    logic [31:0] shadow [0:63];
    logic [31:0] hold_core;
    logic [31:0] hold_dbg;
    int          conf_model;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [31:0] caddr,
                                input logic [3:0] cbe, input logic [31:0] cwd,
                                input logic dreq, input logic dwe, input logic [31:0] daddr,
                                input logic [3:0] dbe, input logic [31:0] dwd,
                                input logic ecg, input logic edg);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cbe = cbe; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dbe = dbe; v.dwd = dwd;
        v.exp_cg = ecg; v.exp_dg = edg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        core_bus.req = v.creq; core_bus.we = v.cwe; core_bus.addr = v.caddr;
        core_bus.be = v.cbe; core_bus.wdata = v.cwd;
        dbg_bus.req = v.dreq; dbg_bus.we = v.dwe; dbg_bus.addr = v.daddr;
        dbg_bus.be = v.dbe; dbg_bus.wdata = v.dwd;
    endtask

    task automatic clear_model();
        sb.delete();
        hold_core = '0;
        hold_dbg = '0;
        conf_model = 0;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    endtask

    task automatic check_returns();
        bit          ecv = 1'b0;
        bit          edv = 1'b0;
        logic [31:0] ecd = hold_core;
        logic [31:0] edd = hold_dbg;
        if (sb.size() > 0) begin
            rd_exp_t e = sb.pop_front();
            if (e.is_dbg) begin edv = 1'b1; edd = e.data; end
            else begin ecv = 1'b1; ecd = e.data; end
        end
        chk("core_rvalid", 32'(core_bus.rvalid), 32'(ecv));
        chk("dbg_rvalid", 32'(dbg_bus.rvalid), 32'(edv));
        chk("core_rdata", core_bus.rdata, ecd);
        chk("dbg_rdata", dbg_bus.rdata, edd);
        hold_core = ecd;
        hold_dbg = edd;
    endtask

    // One cycle: drive after the edge, compare at the falling edge, then update the model.
    task automatic apply(input vec_t v);
        logic          g_any, g_we;
        logic [31:0]   g_addr, g_wd;
        logic [3:0]    g_be;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(v);
        @(negedge clk);
        check_returns();
`ifdef DM_ARB_PERF_EN
        chk("conflict_cnt", conflict_cnt, 32'(conf_model));
`endif
        g_any  = v.exp_cg | v.exp_dg;
        g_we   = v.exp_cg ? v.cwe : (v.exp_dg ? v.dwe : 1'b0);
        g_addr = v.exp_cg ? v.caddr : (v.exp_dg ? v.daddr : 32'h0);
        g_be   = v.exp_cg ? v.cbe : (v.exp_dg ? v.dbe : 4'h0);
        g_wd   = v.exp_cg ? v.cwd : (v.exp_dg ? v.dwd : 32'h0);
        chk("core_gnt", 32'(core_bus.gnt), 32'(v.exp_cg));
        chk("dbg_gnt", 32'(dbg_bus.gnt), 32'(v.exp_dg));
        chk("core_stall", 32'(core_bus.stall), 32'(v.creq & ~v.exp_cg));
        chk("mem_en", 32'(mem_en), 32'(g_any));
        chk("mem_we", 32'(mem_we), 32'(g_we ? g_be : 4'h0));
        chk("mem_addr", mem_addr, {g_addr[31:2], 2'b00});
        chk("mem_wdata", mem_wdata, g_wd);
        $display("step %0d: creq=%0b dreq=%0b core_gnt=%0b dbg_gnt=%0b mem_en=%0b addr=%h we=%b",
                 cyc, v.creq, v.dreq, core_bus.gnt, dbg_bus.gnt, mem_en, mem_addr, mem_we);
        if (g_any && !g_we) begin
            rd_exp_t e;
            e.is_dbg = v.exp_dg;
            e.data = shadow[g_addr[7:2]];
            sb.push_back(e);
        end else if (g_any) begin
            for (int b = 0; b < BW; b++)
                if (g_be[b]) shadow[g_addr[7:2]][8*b +: 8] = g_wd[8*b +: 8];
        end
        if (v.creq && v.dreq) conf_model++;
        cyc++;
    endtask

    // Holds reset for n cycles while both ports request; nothing may be granted or returned.
    task automatic reset_cycles(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(mk(1, 0, 32'h10, 4'hF, 0, 1, 1, 32'h3C, 4'hF, 32'h5555_AAAA, 0, 0));
        @(negedge clk);
        chk("rst_core_gnt", 32'(core_bus.gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_bus.gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_core_rvalid", 32'(core_bus.rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_bus.rvalid), 32'd0);
        $display("step %0d: reset asserted", cyc);
        cyc++;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            chk("rst_core_rvalid", 32'(core_bus.rvalid), 32'd0);
            chk("rst_core_rdata", core_bus.rdata, 32'd0);
            chk("rst_dbg_rdata", dbg_bus.rdata, 32'd0);
            $display("step %0d: reset held", cyc);
            cyc++;
        end
        clear_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle, both_rd, both_dw0;
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        both_rd  = mk(1, 0, 32'h20, 4'hF, 0, 1, 0, 32'h30, 4'hF, 0, 1, 0);
        both_dw0 = mk(1, 0, 32'h20, 4'hF, 0, 1, 1, 32'h00, 4'hF, 32'h1111_1111, 1, 0);

        drive(idle);
        clear_model();
        reset_cycles(3);

        // core read with data return
        tbl.push_back(mk(1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle);
        // both requesting: core wins four times, debug forced on the fifth
        for (int k = 0; k < 4; k++) tbl.push_back(both_rd);
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 1, 0, 32'h30, 4'hF, 0, 0, 1));
        tbl.push_back(both_rd);
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(both_rd);
        tbl.push_back(idle);
        // alternating reads from each port in consecutive cycles
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h24, 4'hF, 0, 0, 1));
        tbl.push_back(idle);
        // misaligned byte write, then read back the merged word
        tbl.push_back(mk(1, 1, 32'h13, 4'b0100, 32'h00AB_0000, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle);
        tbl.push_back(mk(1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle);
        // debug write burst against a continuously requesting core
        for (int k = 0; k < 4; k++) tbl.push_back(both_dw0);
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 1, 1, 32'h00, 4'hF, 32'h1111_1111, 0, 1));
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 1, 1, 32'h04, 4'hF, 32'h2222_2222, 0, 1));
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 1, 1, 32'h08, 4'hF, 32'h3333_3333, 0, 1));
        tbl.push_back(mk(1, 0, 32'h20, 4'hF, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h04, 4'hF, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h00, 4'hF, 0, 1, 0, 32'h08, 4'hF, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h08, 4'hF, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h26, 4'b0011, 0, 0, 1));
        tbl.push_back(idle);

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while the debug wait counter is part-way up; a read issued just before must not return.
        for (int k = 0; k < 3; k++)
            apply(mk(1, 0, 32'h10, 4'hF, 0, 1, 0, 32'h24, 4'hF, 0, 1, 0));
        reset_cycles(2);
        for (int k = 0; k < 4; k++)
            apply(mk(1, 0, 32'h10, 4'hF, 0, 1, 0, 32'h24, 4'hF, 0, 1, 0));
        apply(mk(1, 0, 32'h10, 4'hF, 0, 1, 0, 32'h24, 4'hF, 0, 0, 1));
        apply(idle);

        // Reset in the middle of a locked debug burst clears the lock.
        apply(mk(0, 0, 0, 0, 0, 1, 1, 32'h3C, 4'hF, 32'h7777_0000, 0, 1));
        apply(mk(1, 0, 32'h10, 4'hF, 0, 1, 1, 32'h38, 4'hF, 32'h7777_0001, 0, 1));
        reset_cycles(2);
        apply(mk(1, 0, 32'h10, 4'hF, 0, 1, 1, 32'h38, 4'hF, 32'h7777_0002, 1, 0));
        apply(idle);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Arbitrates the single-port data memory between two requesters.
- Core port: driven by the MEM stage.
- Debug/loader port: used for program/data preload and debug inspection.
- The core has priority. A wait counter guarantees the debug port is served within MAX_WAIT cycles.
- Issues one access per cycle and returns read data one cycle later, tagged to the winning port. Drives the MEM-stage stall.

Parameters:
AW, 32, byte address width
DW, 32, data width (byte enables = DW/8)
MAX_WAIT, 4, max consecutive cycles the debug request loses before it is forced to win (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_core_req  in  1  core access request
i_core_we  in  1  1=write, 0=read
i_core_addr  in  AW  byte address
i_core_be  in  DW/8  byte enables
i_core_wdata  in  DW  write data
o_core_gnt  out  1  core request accepted this cycle (combinational)
o_core_rvalid  out  1  core read data valid
o_core_rdata  out  DW  core read data
o_core_stall  out  1  i_core_req & ~o_core_gnt
i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_be, i_dbg_wdata  in  1/1/AW/DW/8/DW  debug port, same meaning as core
o_dbg_gnt  out  1  debug request accepted
o_dbg_rvalid  out  1  debug read data valid
o_dbg_rdata  out  DW  debug read data
o_mem_en  out  1  memory access this cycle
o_mem_we  out  DW/8  per-byte write enable (0 on reads)
o_mem_addr  out  AW  word-aligned address (addr[1:0] forced 0)
o_mem_wdata  out  DW  write data
i_mem_rdata  in  DW  read data, valid one cycle after a read issue

Behaviour:
- Arbitration is combinational in the request cycle. At most one of o_core_gnt / o_dbg_gnt is high.
- Default winner: core.
- Debug wins if any of the following holds:
  - core not requesting;
  - wait_cnt == MAX_WAIT and i_dbg_req;
  - debug port is locked (see below).
- wait_cnt (4 bits, reg):
  - increments each cycle i_dbg_req=1 and o_dbg_gnt=0;
  - clears on o_dbg_gnt or when i_dbg_req=0;
  - never exceeds MAX_WAIT.
- Lock: after a debug grant with we=1, the debug port keeps priority while i_dbg_req stays high in the immediately following cycles (burst preload). Lock clears the first cycle i_dbg_req=0. The wait_cnt rule for the core does not apply; the core stalls during a lock.
- Memory outputs mirror the granted port:
  - o_mem_en = gnt_any;
  - o_mem_we = be & {DW/8{we}};
  - o_mem_en=0 and outputs zero when no grant.
- Read return:
  - rd_owner (2 bits: none/core/dbg) is registered on a read grant.
  - Next cycle, the matching rvalid = 1 and the rdata of that port = i_mem_rdata; the other port's rdata holds its previous value.
  - A write grant registers owner none.
- Back-to-back reads from alternating ports are allowed. Each return follows its own issue by exactly 1 cycle.
- Misaligned request (addr[1:0]≠0): passed with addr aligned and be unchanged. Alignment and byte-lane placement are the requester's job.
- Reset (rst_n=0 at a clk edge):
  - wait_cnt=0, lock=0, rd_owner=none;
  - all rvalids=0, rdatas=0;
  - mem outputs are combinational, so no grants are given while rst_n=0.
  - A read issued in the cycle reset asserts produces no rvalid.

Optional Feature:
DM_ARB_PERF_EN:
- With it: adds output o_conflict_cnt [31:0]. This counter increments in each cycle where both i_core_req and i_dbg_req are high, saturates at 0xFFFFFFFF, and resets to 0.
- Without it: the port and counter are absent. Arbitration is identical.

Test Plan:
- Core read only, addr 0x10, mem returns 0xDEADBEEF -> o_core_gnt=1 same cycle, o_mem_addr=0x10, o_core_rvalid=1 and o_core_rdata=0xDEADBEEF next cycle, o_core_stall=0.
- Both request continuously, MAX_WAIT=4 -> core granted for 4 cycles, dbg granted in 5th, o_core_stall=1 only in that 5th cycle, wait_cnt back to 0.
- Debug write burst to 0x0,0x4,0x8 with core also requesting -> after first dbg win, dbg granted 3 consecutive cycles, core stalls until i_dbg_req drops, then core granted.
- Alternating reads core@0x20 then dbg@0x24 in consecutive cycles -> o_core_rvalid in cycle 2, o_dbg_rvalid in cycle 3, each with its own data; no cross-delivery.
- Core byte write be=4'b0100 we=1 addr 0x13 -> o_mem_we=4'b0100, o_mem_addr=0x10, no rvalid next cycle.
- Reset asserted the cycle after a core read issue -> o_core_rvalid stays 0, wait_cnt=0, lock=0. With DM_ARB_PERF_EN: o_conflict_cnt=0.
